// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing a single-port synchronous RAM between CPU and debug masters
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic [DW-1:0] c_rdata,
    output logic          c_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

    state_t        state_q, state_d;
    logic          last_dbg_q, last_dbg_d;
    logic [HW-1:0] hold_q, hold_d, hold_nxt;
    logic          c_rv_q, d_rv_q;
    logic          c_xfer, d_xfer, own_req, oth_req;

    assign c_gnt     = state_q == OWN_C;
    assign d_gnt     = state_q == OWN_D;
    assign c_xfer    = c_req && c_gnt;
    assign d_xfer    = d_req && d_gnt;
    assign mem_addr  = c_gnt ? c_addr : d_gnt ? d_addr : '0;
    assign mem_wdata = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
    assign mem_we    = !reset && ((c_xfer && c_we) || (d_xfer && d_we));
    assign c_rvalid  = c_rv_q;
    assign d_rvalid  = d_rv_q;
    assign c_rdata   = c_rv_q ? mem_rdata : '0;
    assign d_rdata   = d_rv_q ? mem_rdata : '0;

    always_comb begin
        state_d    = state_q;
        last_dbg_d = last_dbg_q;
        hold_d     = hold_q;
        own_req    = c_gnt ? c_req : d_req;
        oth_req    = c_gnt ? d_req : c_req;
        // tenure counter saturates so a sole requester never sees a wrap
        hold_nxt   = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(own_req);
        if (state_q == IDLE) begin
            if (c_req && (!d_req || last_dbg_q))
                state_d = OWN_C;
            else if (d_req)
                state_d = OWN_D;
        end else if (oth_req && (!own_req || hold_nxt == HW'(MAX_HOLD))) begin
            state_d    = c_gnt ? OWN_D : OWN_C;
            last_dbg_d = d_gnt;
            hold_d     = '0;
        end else if (!own_req) begin
            state_d    = IDLE;
            last_dbg_d = d_gnt;
            hold_d     = '0;
        end else begin
            hold_d = hold_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dbg_q <= 1'b1;
            hold_q     <= '0;
            c_rv_q     <= 1'b0;
            d_rv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
            hold_q     <= hold_d;
            c_rv_q     <= c_xfer && !c_we;
            d_rv_q     <= d_xfer && !d_we;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural synchronous RAM
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic       c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
    logic [7:0] c_rdata, d_rdata, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;
    logic [7:0] ram [256];
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic rst, input logic cr, input logic cw, input logic [7:0] ca,
                         input logic [7:0] cd, input logic dr, input logic dw,
                         input logic [7:0] da, input logic [7:0] dd);
        @(negedge clk);
        reset = rst; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
    endtask

    task automatic do_reset;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    initial begin
        logic ec, ed;
        preload(8'h20, 8'h5C);
        preload(8'h30, 8'h11);

        // CPU alone: write then read back
        do_reset;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_c_rdata", c_rdata, 0);
        drive(0, 1, 1, 8'h10, 8'hAB, 0, 0, 0, 0);
        chk("solo_idle_gnt", c_gnt, 0);
        chk("solo_idle_we", mem_we, 0);
        drive(0, 1, 1, 8'h10, 8'hAB, 0, 0, 0, 0);
        chk("solo_wr_gnt", c_gnt, 1);
        chk("solo_wr_we", mem_we, 1);
        chk("solo_wr_addr", mem_addr, 8'h10);
        chk("solo_wr_data", mem_wdata, 8'hAB);
        drive(0, 1, 0, 8'h10, 0, 0, 0, 0, 0);
        chk("solo_rd_we", mem_we, 0);
        chk("solo_wr_no_rvalid", c_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("solo_rvalid", c_rvalid, 1);
        chk("solo_rdata", c_rdata, 8'hAB);
        chk("solo_d_rvalid", d_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("solo_release", c_gnt, 0);
        chk("solo_rvalid_clr", c_rvalid, 0);
        chk("solo_rdata_clr", c_rdata, 0);

        // tie from IDLE: CPU x4, debug x4, CPU again
        do_reset;
        for (int i = 0; i <= 12; i++) begin
            drive(0, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
            ec = (i >= 1 && i <= 4) || i >= 9;
            ed = i >= 5 && i <= 8;
            chk($sformatf("tie_c_gnt_%0d", i), c_gnt, ec);
            chk($sformatf("tie_d_gnt_%0d", i), d_gnt, ed);
            chk($sformatf("tie_addr_%0d", i), mem_addr, ec ? 8'h01 : ed ? 8'h02 : 8'h00);
        end

        // early release after 2 CPU transfers
        do_reset;
        for (int i = 0; i <= 2; i++) drive(0, 1, 0, 8'h03, 0, 1, 0, 8'h04, 0);
        chk("early_c_gnt", c_gnt, 1);
        drive(0, 0, 0, 8'h03, 0, 1, 0, 8'h04, 0);
        chk("early_c_hold", c_gnt, 1);
        chk("early_d_wait", d_gnt, 0);
        drive(0, 0, 0, 8'h03, 0, 1, 0, 8'h04, 0);
        chk("early_d_gnt", d_gnt, 1);
        chk("early_c_drop", c_gnt, 0);

        // read issued on the CPU's last granted cycle returns during debug ownership
        do_reset;
        for (int i = 0; i <= 4; i++)
            drive(0, 1, i < 4, i < 4 ? 8'h21 : 8'h20, 8'h77, 1, 0, 8'h40, 0);
        chk("xh_last_c_gnt", c_gnt, 1);
        chk("xh_last_addr", mem_addr, 8'h20);
        chk("xh_last_rvalid", c_rvalid, 0);
        drive(0, 1, 0, 8'h20, 0, 1, 0, 8'h40, 0);
        chk("xh_d_gnt", d_gnt, 1);
        chk("xh_c_gnt", c_gnt, 0);
        chk("xh_c_rvalid", c_rvalid, 1);
        chk("xh_c_rdata", c_rdata, 8'h5C);
        chk("xh_d_rvalid", d_rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("xh_d_rvalid_next", d_rvalid, 1);
        chk("xh_c_rvalid_next", c_rvalid, 0);

        // reset during a CPU write suppresses it and drops ownership
        do_reset;
        drive(0, 1, 0, 8'h30, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 8'h30, 0, 0, 0, 0, 0);
        chk("rb_c_gnt", c_gnt, 1);
        drive(1, 1, 1, 8'h30, 8'hFF, 0, 0, 0, 0);
        chk("rb_we_suppressed", mem_we, 0);
        chk("rb_rvalid_before", c_rvalid, 1);
        chk("rb_rdata_before", c_rdata, 8'h11);
        drive(0, 1, 0, 8'h30, 0, 0, 0, 0, 0);
        chk("rb_c_gnt_after", c_gnt, 0);
        chk("rb_d_gnt_after", d_gnt, 0);
        chk("rb_c_rvalid_after", c_rvalid, 0);
        chk("rb_d_rvalid_after", d_rvalid, 0);
        drive(0, 1, 0, 8'h30, 0, 0, 0, 0, 0);
        chk("rb_regrant", c_gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rb_readback_valid", c_rvalid, 1);
        chk("rb_readback_data", c_rdata, 8'h11);

        // sole debug requester keeps ownership past the tenure limit
        do_reset;
        drive(0, 0, 0, 0, 0, 1, 1, 8'h80, 8'h00);
        chk("sat_idle", d_gnt, 0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1, 8'h80 + 8'(i), 8'(i));
            chk($sformatf("sat_d_gnt_%0d", i), d_gnt, 1);
            chk($sformatf("sat_we_%0d", i), mem_we, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_ram_last", ram[8'h94], 8'h14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the machine's single-port 8-bit RAM between the CPU bus master and a debug/loader master (program load, memory inspection after halt). Owns the RAM address, write-enable and write-data lines. Enforces fair round-robin ownership with a bounded tenure so that neither master starves. Read data comes back one cycle after the access, matching the RAM's synchronous read.

Parameters:
AW, 8, address width
DW, 8, data width
MAX_HOLD, 4, max transfers one owner may complete while the other requests (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU requests a transfer this cycle
c_we  in  1  CPU transfer is a write
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_gnt  out  1  CPU owns RAM this cycle
c_rdata  out  DW  CPU read data
c_rvalid  out  1  c_rdata valid (one cycle after CPU read transfer)
d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug master, same meaning as CPU
d_gnt, d_rdata, d_rvalid  out  1/DW/1  debug master, same meaning as CPU
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid the cycle after address is presented

Behaviour:
- Only one clock domain (clk); reset is synchronous and active-high; all state updates on posedge clk.
- Reset values:
  - state=IDLE; last_owner=DBG, so the CPU wins the first tie.
  - hold_cnt=0.
  - c_gnt=d_gnt=0, c_rvalid=d_rvalid=0.
  - c_rdata=d_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, OWN_C, OWN_D. Grants are decodes of the registered state: c_gnt=(state==OWN_C), d_gnt=(state==OWN_D).
- Transfer: occurs in any cycle where x_req && x_gnt.
  - mem_addr, mem_wdata and mem_we follow the owner's signals combinationally.
  - mem_we=owner_we only during a transfer, else 0.
  - When there is no transfer, mem_addr/mem_wdata hold the owner's values (0 in IDLE).
  - mem_we is 0 whenever reset=1.
- Read return: a read transfer in cycle N gives x_rvalid=1 in cycle N+1, with x_rdata=mem_rdata. rvalid/rdata are routed to the master that issued the read, even if ownership changed in between.
  - x_rdata=0 when x_rvalid=0.
  - Writes never raise rvalid.
- IDLE:
  - No transfers take place in IDLE (one-cycle arbitration latency).
  - Only c_req high -> OWN_C. Only d_req high -> OWN_D.
  - Both high -> the master that is not last_owner.
  - Neither high -> stay in IDLE.
- OWN_x:
  - hold_cnt_next = min(hold_cnt + transfer, MAX_HOLD).
  - Handover: if other_req && (!x_req || hold_cnt_next==MAX_HOLD), next state = OWN_other, last_owner=x, hold_cnt=0.
  - Else if !x_req -> IDLE, last_owner=x, hold_cnt=0.
  - Else stay, hold_cnt=hold_cnt_next.
  - A sole requester keeps ownership indefinitely; hold_cnt saturates and does not wrap.
- Handover has no idle cycle: the new owner's gnt rises the cycle after the old owner's last granted cycle. There is never a cycle with both gnts high.
- Request changes: an owner may change addr/we/wdata every cycle; each cycle with req high is an independent transfer.
- Reset mid-operation: a write in the reset cycle is suppressed. Pending rvalid is dropped (0 the next cycle). State returns to IDLE.

Test Plan:
- CPU alone: reset, then c_req=1 write addr 0x10 data 0xAB. -> c_gnt rises 1 cycle after c_req; the write lands in that cycle. Read 0x10 next -> c_rvalid=1, c_rdata=0xAB one cycle later; d_rvalid stays 0.
- Tie from IDLE after reset: c_req=d_req=1 in the same cycle. -> CPU granted first. With MAX_HOLD=4, CPU completes exactly 4 transfers. d_gnt rises the very next cycle. After 4 debug transfers, ownership returns to the CPU.
- Early release: CPU owner drops c_req after 2 transfers while d_req=1. -> d_gnt next cycle, no IDLE cycle, never both gnts high.
- Read across handover: CPU's last transfer is a read of 0x20 (preloaded 0x5C), followed immediately by debug ownership. -> c_rvalid=1 with 0x5C in the debug master's first granted cycle; d_rvalid=0 in that cycle.
- Reset mid-burst: assert reset during a CPU write of 0xFF to 0x30 (old value 0x11). -> mem_we=0 in that cycle, 0x30 reads back 0x11, state IDLE, all gnt/rvalid 0 the next cycle.
- Solo saturation: d_req held high for 20 cycles with c_req=0. -> d_gnt stays high for all 20 cycles, with no forced release and no counter wrap glitch.
